pixel_stream_packer: RTL and testbench
======================================

PIXEL_STREAM_PACKER -- requirements
Module: pixel_stream_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output-buffer depth in pixels; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter PAD_BYTE, default 8'h00, value placed in tdata[31:24].
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port image_width, input, 13 bits: pixels per line.
REQ-006 SHALL have port image_height, input, 13 bits: lines per frame.
REQ-007 SHALL have ports in_red, in_green and in_blue, input, 8 bits each: pixel from the ray-tracing unit.
REQ-008 SHALL have ports in_valid, in_sof and in_eol, input, 1 bit each: pixel qualifier, start-of-frame and end-of-line.
REQ-009 SHALL have port in_ready, output, 1 bit: drives the ray-tracing unit's ReadyExternal.
REQ-010 SHALL have ports m_axis_tdata (output, 32 bits), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tuser (output, 1, SOF) and m_axis_tlast (output, 1, EOL), forming the AXI4-Stream video master.
REQ-011 SHALL have port err_flags, output, 3 bits, sticky: [0] early EOL, [1] late/missing EOL, [2] unexpected SOF.
REQ-012 SHALL have port err_clear, input, 1 bit: synchronous clear of err_flags.
REQ-013 SHALL have port frame_count, output, 16 bits: number of completed frames.

Function
REQ-014 SHALL accept an input pixel on a cycle with in_valid && in_ready.
REQ-015 SHALL drive in_ready from a register only: in_ready = (FIFO occupancy < FIFO_DEPTH), with no combinational path from m_axis_tready.
REQ-016 SHALL pack tdata = {PAD_BYTE, red, green, blue}; tuser = stored SOF; tlast = stored EOL.
REQ-017 SHALL have latency of one cycle: a pixel accepted in cycle N is visible on m_axis in cycle N+1 at the earliest.
REQ-018 SHALL hold m_axis outputs stable while tvalid && !tready, per AXI rules.
REQ-019 SHALL permit a simultaneous push and pop in one cycle, leaving occupancy unchanged.
REQ-020 SHALL, at FIFO full, hold in_ready at 0 from the cycle after the push that reached FIFO_DEPTH until a pop occurs.
REQ-021 SHALL, at FIFO empty, hold tvalid at 0; a pixel is never dropped once accepted in ACTIVE.
REQ-022 SHALL implement FSM WAIT_SOF -> ACTIVE on an accepted pixel with in_sof=1.
REQ-023 SHALL, in WAIT_SOF, accept and discard pixels without SOF, keeping in_ready=1, with no FIFO write.
REQ-024 SHALL, in ACTIVE, keep an x counter (0..image_width-1) and a y counter (0..image_height-1) that advance on each accepted pixel.
REQ-025 SHALL, on an accepted in_eol, reset x to 0 and increment y.
REQ-026 SHALL, on the final pixel (x=image_width-1, y=image_height-1, EOL), increment frame_count (wrapping modulo 2^16), return to WAIT_SOF, and clear x and y.
REQ-027 SHALL set err[0] when in_eol arrives with x != image_width-1; the counters still follow in_eol.
REQ-028 SHALL set err[1] when x = image_width-1 and in_eol=0; x then wraps to 0 and y increments.
REQ-029 SHALL set err[2] when in_sof arrives in ACTIVE at a position other than (0,0); it restarts the counters at (0,0) and forwards the pixel.
REQ-030 SHALL give set priority over err_clear when both occur in the same cycle.

Reset
REQ-031 SHALL, on reset assertion, immediately (asynchronously) set: in_ready=0, tvalid=0, tdata=0, tuser=0, tlast=0, err_flags=0, frame_count=0, FSM=WAIT_SOF, x=y=0, FIFO empty.
REQ-032 SHALL raise in_ready on the first clock edge after reset deassertion.
REQ-033 SHALL, when reset is asserted mid-frame, discard all buffered pixels, and the next output frame SHALL begin only with a fresh SOF.

Configuration
REQ-034 SHALL support macro PIXEL_STREAM_PACKER_FRAME_CHECK_EN.
REQ-035 SHALL, when the macro is defined, implement the x/y counters, err_flags and frame_count as specified above.
REQ-036 SHALL, when the macro is undefined, tie err_flags=0 and frame_count=0, omit the counters, and still apply the WAIT_SOF/ACTIVE SOF gating, with ACTIVE never exited except by reset.

Structure
REQ-037 SHALL place the packed-pixel struct (r, g, b, sof, eol), the FSM state enum and the err bit-index constants in package pixel_stream_pkg.
REQ-038 SHALL implement the buffer as one sub-module, pixel_fifo (parameterised depth, registered full/empty flags, simultaneous read/write); the FSM and checker SHALL sit in the top.

Verification
REQ-039 SHALL verify: 4x2 frame, tready=1, SOF first and EOL at x=3 -> 8 beats, tuser on beat 0, tlast on beats 3 and 7, frame_count=1, err=0.
REQ-040 SHALL verify: 3 pixels without SOF after reset, then a valid frame -> the first 3 pixels are dropped, output starts at the SOF pixel.
REQ-041 SHALL verify: tready=0 with FIFO_DEPTH=4 and 6 pixels offered -> in_ready low after the 4th acceptance, no loss, order preserved once tready=1.
REQ-042 SHALL verify: width 4, EOL at x=2 -> err=3'b001; width 4, no EOL at x=3 -> err=3'b010; then err_clear -> 0.
REQ-043 SHALL verify: SOF at (2,0) in ACTIVE -> err=3'b100, counters restart, pixel forwarded with tuser=1.
REQ-044 SHALL verify: reset pulse with 2 pixels buffered -> tvalid=0 immediately, frame_count=0, next output beat carries tuser=1.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared types for the pixel stream packer: pixel bundle, FSM state,
// and error-flag bit positions.
package pixel_stream_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
  } pixel_t;

  typedef enum logic {
    WAIT_SOF,
    ACTIVE
  } state_t;

  localparam int ERR_EARLY_EOL = 0;
  localparam int ERR_LATE_EOL  = 1;
  localparam int ERR_SOF       = 2;

endpackage

// File: rtl/pixel_fifo.sv
// Pixel output buffer: power-of-two depth, registered full/empty,
// simultaneous push and pop.
module pixel_fifo
  import pixel_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  pixel_t wdata,
  input  logic   pop,
  output pixel_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [AW:0]     cnt;
  logic [AW:0]     cnt_n;
  logic            wr;
  logic            rd;

  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign rdata = mem[rp];

  always_comb begin
    cnt_n = cnt;
    if (wr && !rd)
      cnt_n = cnt + (AW+1)'(1);
    else if (rd && !wr)
      cnt_n = cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr)
        wp <= wp + AW'(1);
      if (rd)
        rp <= rp + AW'(1);
      cnt   <= cnt_n;
      full  <= (cnt_n == (AW+1)'(DEPTH));
      empty <= (cnt_n == '0);
    end
  end

  // Storage carries no reset; the top masks outputs while empty.
  always_ff @(posedge clk) begin
    if (wr)
      mem[wp] <= wdata;
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs ray-tracer pixels into an AXI4-Stream video master with SOF gating.
// Optional frame checker enabled by PIXEL_STREAM_PACKER_FRAME_CHECK_EN.
module pixel_stream_packer
  import pixel_stream_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] PAD_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] image_width,
  input  logic [12:0] image_height,
  input  logic [7:0]  in_red,
  input  logic [7:0]  in_green,
  input  logic [7:0]  in_blue,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eol,
  output logic        in_ready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [2:0]  err_flags,
  input  logic        err_clear,
  output logic [15:0] frame_count
);

  state_t state;
  state_t state_n;
  pixel_t wpx;
  pixel_t rpx;
  logic   rdy_en;
  logic   full;
  logic   empty;
  logic   acc;
  logic   fwd;
  logic   done;

  // in_ready depends only on registers, never on m_axis_tready.
  assign in_ready = rdy_en & ~full;
  assign acc      = in_valid & in_ready;
  assign fwd      = acc & ((state == ACTIVE) | in_sof);

  always_comb begin
    wpx     = '0;
    wpx.r   = in_red;
    wpx.g   = in_green;
    wpx.b   = in_blue;
    wpx.sof = in_sof;
    wpx.eol = in_eol;
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fwd),
    .wdata (wpx),
    .pop   (m_axis_tready),
    .rdata (rpx),
    .full  (full),
    .empty (empty)
  );

  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = empty ? 32'h0
                       : {PAD_BYTE, rpx.r, rpx.g, rpx.b};
  assign m_axis_tuser  = ~empty & rpx.sof;
  assign m_axis_tlast  = ~empty & rpx.eol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en <= 1'b0;
      state  <= WAIT_SOF;
    end else begin
      rdy_en <= 1'b1;
      state  <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_SOF: if (fwd) state_n = ACTIVE;
      ACTIVE:   state_n = ACTIVE;
    endcase
    if (done)
      state_n = WAIT_SOF;
  end

`ifdef PIXEL_STREAM_PACKER_FRAME_CHECK_EN
  logic [12:0] x;
  logic [12:0] y;
  logic [12:0] x_n;
  logic [12:0] y_n;
  logic [12:0] cx;
  logic [12:0] cy;
  logic [12:0] wm1;
  logic [12:0] hm1;
  logic        last_x;
  logic        last_y;
  logic [2:0]  err;
  logic [2:0]  err_set;
  logic [15:0] fcnt;

  // An SOF pixel is always treated as position (0,0).
  always_comb begin
    wm1     = image_width - 13'd1;
    hm1     = image_height - 13'd1;
    cx      = in_sof ? 13'd0 : x;
    cy      = in_sof ? 13'd0 : y;
    last_x  = (cx == wm1);
    last_y  = (cy == hm1);
    err_set = '0;
    x_n     = x;
    y_n     = y;
    done    = 1'b0;
    if (fwd) begin
      err_set[ERR_SOF] = (state == ACTIVE) & in_sof
                       & ((x != '0) | (y != '0));
      err_set[ERR_EARLY_EOL] = in_eol & ~last_x;
      err_set[ERR_LATE_EOL]  = ~in_eol & last_x;
      if (in_eol && last_x && last_y) begin
        done = 1'b1;
        x_n  = '0;
        y_n  = '0;
      end else if (in_eol || last_x) begin
        x_n = '0;
        y_n = last_y ? 13'd0 : cy + 13'd1;
      end else begin
        x_n = cx + 13'd1;
        y_n = cy;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      err  <= '0;
      fcnt <= '0;
    end else begin
      x   <= x_n;
      y   <= y_n;
      err <= (err & ~{3{err_clear}}) | err_set;
      if (done)
        fcnt <= fcnt + 16'd1;
    end
  end

  assign err_flags   = err;
  assign frame_count = fcnt;
`else
  logic unused_cfg;

  assign unused_cfg  = ^{image_width, image_height, err_clear};
  assign done        = 1'b0;
  assign err_flags   = '0;
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed testbench for pixel_stream_packer; frame/err expectations
// follow PIXEL_STREAM_PACKER_FRAME_CHECK_EN.
module tb_pixel_stream_packer;

`ifdef PIXEL_STREAM_PACKER_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] image_width;
  logic [12:0] image_height;
  logic [7:0]  in_red;
  logic [7:0]  in_green;
  logic [7:0]  in_blue;
  logic        in_valid;
  logic        in_sof;
  logic        in_eol;
  logic        in_ready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [2:0]  err_flags;
  logic        err_clear;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  logic [33:0] q[$];

  pixel_stream_packer dut (
    .clk           (clk),
    .reset         (reset),
    .image_width   (image_width),
    .image_height  (image_height),
    .in_red        (in_red),
    .in_green      (in_green),
    .in_blue       (in_blue),
    .in_valid      (in_valid),
    .in_sof        (in_sof),
    .in_eol        (in_eol),
    .in_ready      (in_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .err_flags     (err_flags),
    .err_clear     (err_clear),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready)
      q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    if (in_valid && in_ready)
      acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_px(input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input logic s,
                          input logic e);
    int k;
    in_red   = r;
    in_green = g;
    in_blue  = b;
    in_sof   = s;
    in_eol   = e;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100)
      chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("beat_count", 64'(q.size()), 64'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr;
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    image_width   = 13'd4;
    image_height  = 13'd2;
    in_red        = '0;
    in_green      = '0;
    in_blue       = '0;
    in_valid      = 1'b0;
    in_sof        = 1'b0;
    in_eol        = 1'b0;
    m_axis_tready = 1'b1;
    err_clear     = 1'b0;

    // reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_err", 64'(err_flags), 64'd0);
    chk("rst_fc", 64'(frame_count), 64'd0);
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // three non-SOF pixels are dropped, then a 4x2 frame
    for (int i = 0; i < 3; i++)
      drive_px(8'hAA, 8'hBB, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      drive_px(8'(i), 8'(8'h10 + i), 8'(8'h20 + i),
               i == 0, i == 3 || i == 7);
    wait_beats(8);
    idle(4);
    chk("f1_no_extra", 64'(q.size()), 64'd8);
    chk("f1_beat0", 64'(q[0]), {30'd0, 2'b10, 32'h00001020});
    chk("f1_beat1", 64'(q[1]), {30'd0, 2'b00, 32'h00011121});
    chk("f1_beat3", 64'(q[3]), {30'd0, 2'b01, 32'h00031323});
    chk("f1_beat4", 64'(q[4]), {30'd0, 2'b00, 32'h00041424});
    chk("f1_beat7", 64'(q[7]), {30'd0, 2'b01, 32'h00071727});
    chk("f1_fc", 64'(frame_count), CHK ? 64'd1 : 64'd0);
    chk("f1_err", 64'(err_flags), 64'd0);
    q.delete();

    // backpressure: 6 pixels into a 4-deep buffer
    image_width   = 13'd6;
    image_height  = 13'd1;
    m_axis_tready = 1'b0;
    acc_cnt       = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive_px(8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i),
                   i == 0, i == 5);
      end
      begin
        idle(8);
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        chk("bp_accepted", 64'(acc_cnt), 64'd4);
        chk("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("bp_hold", 64'(m_axis_tdata), 64'h00405060);
        chk("bp_none_out", 64'(q.size()), 64'd0);
        m_axis_tready = 1'b1;
      end
    join
    wait_beats(6);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] e;
      e = 32'h00405060 + 32'h00010101 * i;
      chk("bp_order", 64'(q[i]),
          {30'd0, i == 0, i == 5, e});
    end
    chk("bp_fc", 64'(frame_count), CHK ? 64'd2 : 64'd0);
    q.delete();

    // early EOL, then missing EOL
    image_width  = 13'd4;
    image_height = 13'd2;
    for (int i = 0; i < 3; i++)
      drive_px(8'(8'h80 + i), 8'(8'h90 + i), 8'(8'hA0 + i),
               i == 0, i == 2);
    chk("err_early", 64'(err_flags), CHK ? 64'h1 : 64'h0);
    clr();
    chk("err_clr1", 64'(err_flags), 64'h0);
    for (int i = 3; i < 7; i++)
      drive_px(8'(8'h80 + i), 8'(8'h90 + i), 8'(8'hA0 + i),
               1'b0, 1'b0);
    chk("err_late", 64'(err_flags), CHK ? 64'h2 : 64'h0);
    clr();
    chk("err_clr2", 64'(err_flags), 64'h0);
    idle(4);
    q.delete();

    // SOF at (2,0) while active
    for (int i = 7; i < 10; i++)
      drive_px(8'(8'h80 + i), 8'(8'h90 + i), 8'(8'hA0 + i),
               i == 9, 1'b0);
    chk("err_sof", 64'(err_flags), CHK ? 64'h4 : 64'h0);
    wait_beats(3);
    chk("sof_fwd", 64'(q[2]), {30'd0, 2'b10, 32'h008999A9});
    for (int i = 10; i < 13; i++)
      drive_px(8'(8'h80 + i), 8'(8'h90 + i), 8'(8'hA0 + i),
               1'b0, i == 12);
    chk("sof_restart", 64'(err_flags), CHK ? 64'h4 : 64'h0);
    for (int i = 13; i < 17; i++)
      drive_px(8'(8'h80 + i), 8'(8'h90 + i), 8'(8'hA0 + i),
               1'b0, i == 16);
    chk("sof_fc", 64'(frame_count), CHK ? 64'd3 : 64'd0);
    idle(4);
    q.delete();

    // reset with two pixels buffered
    m_axis_tready = 1'b0;
    drive_px(8'hC0, 8'hC1, 8'hC2, 1'b1, 1'b0);
    drive_px(8'hC3, 8'hC4, 8'hC5, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(m_axis_tvalid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("mid_rst_fc", 64'(frame_count), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    #3;
    reset = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    drive_px(8'hD0, 8'hD1, 8'hD2, 1'b0, 1'b0);
    drive_px(8'hE0, 8'hE1, 8'hE2, 1'b1, 1'b0);
    wait_beats(1);
    idle(4);
    chk("post_rst_count", 64'(q.size()), 64'd1);
    chk("post_rst_beat", 64'(q[0]), {30'd0, 2'b10, 32'h00E0E1E2});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
